// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32I-subset core: walks the shared datapath
// through FETCH/DECODE/EXEC/MEM/WB from a one-hot decode and counts retired instructions.
module multicycle_ctrl #(
    parameter int unsigned MAX_INSTR   = 0,
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [22:0] instruction_type,
    input  logic        branch_taken,
    input  logic        mem_stall_I,
    input  logic        mem_stall_D,
    output logic        mem_cen_I,
    output logic        mem_cen_D,
    output logic        mem_wen_D,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt,
    output logic        illegal,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [7:0] STALL_MAX = STALL_LIMIT[7:0];
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_IMM    = 2'd1;
    localparam logic [1:0] PC_RS1    = 2'd2;
    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_LINK   = 2'd2;

    state_t      state_q, state_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic [5:0]  kind_q;           // {JAL, JALR, BEQ, BNE, LW, SW}; ALU ops are the all-zero case
    logic        latch_kind, set_illegal, set_timeout, clear_flags;
    logic        stall_expired, last_instr;
    state_t      retire_state;

    wire is_jal    = kind_q[5];
    wire is_jalr   = kind_q[4];
    wire is_branch = kind_q[3] | kind_q[2];
    wire is_lw     = kind_q[1];
    wire is_sw     = kind_q[0];

    assign stall_expired = (stall_cnt_q == STALL_MAX);
    assign last_instr    = stop || ((MAX_INSTR != 0) && (instr_cnt + 32'd1 == MAX_INSTR));
    assign retire_state  = last_instr ? S_IDLE : S_FETCH;
    assign state         = state_q;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        latch_kind  = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        clear_flags = 1'b0;
        mem_cen_I   = 1'b0;
        mem_cen_D   = 1'b0;
        mem_wen_D   = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_PLUS4;
        reg_we      = 1'b0;
        wb_sel      = WB_ALU;
        retire      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    clear_flags = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!mem_stall_I) begin
                    mem_cen_I   = 1'b1;
                    ir_we       = 1'b1;
                    stall_cnt_d = '0;
                    state_d     = S_DECODE;
                end else if (stall_expired) begin
                    set_timeout = 1'b1;
                    stall_cnt_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    mem_cen_I   = 1'b1;
                    stall_cnt_d = stall_cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                latch_kind = 1'b1;
                if ($countones(instruction_type) != 1) begin
                    set_illegal = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? PC_IMM : PC_PLUS4;
                    retire  = 1'b1;
                    state_d = retire_state;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_stall_D && stall_expired) begin
                    set_timeout = 1'b1;
                    stall_cnt_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    mem_cen_D = 1'b1;
                    mem_wen_D = is_sw;
                    if (mem_stall_D) begin
                        stall_cnt_d = stall_cnt_q + 8'd1;
                    end else begin
                        stall_cnt_d = '0;
                        if (is_sw) begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = retire_state;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                wb_sel  = is_lw ? WB_MEM : (is_jal || is_jalr) ? WB_LINK : WB_ALU;
                pc_sel  = is_jal ? PC_IMM : is_jalr ? PC_RS1 : PC_PLUS4;
                state_d = retire_state;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            stall_cnt_q <= '0;
            kind_q      <= '0;
            instr_cnt   <= '0;
            illegal     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            if (latch_kind)  kind_q    <= instruction_type[22:17];
            if (retire)      instr_cnt <= instr_cnt + 32'd1;
            if (clear_flags) begin
                illegal <= 1'b0;
                timeout <= 1'b0;
            end
            if (set_illegal) illegal <= 1'b1;
            if (set_timeout) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random instruction
// streams checked cycle-by-cycle against a phase-list model of each instruction.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, branch_taken, mem_stall_I, mem_stall_D;
    logic [22:0] instruction_type;

    logic        mem_cen_I, mem_cen_D, mem_wen_D, ir_we, pc_we, reg_we, retire, illegal, timeout;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    logic        m_mem_cen_I, m_mem_cen_D, m_mem_wen_D, m_ir_we, m_pc_we, m_reg_we, m_retire;
    logic        m_illegal, m_timeout;
    logic [1:0]  m_pc_sel, m_wb_sel;
    logic [2:0]  m_state;
    logic [31:0] m_instr_cnt;

    logic [13:0] strobes;
    int          errors = 0;
    int          checks = 0;
    int          model_cnt = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .instruction_type(instruction_type), .branch_taken(branch_taken),
        .mem_stall_I(mem_stall_I), .mem_stall_D(mem_stall_D),
        .mem_cen_I(mem_cen_I), .mem_cen_D(mem_cen_D), .mem_wen_D(mem_wen_D),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
        .retire(retire), .state(state), .instr_cnt(instr_cnt),
        .illegal(illegal), .timeout(timeout)
    );

    multicycle_ctrl #(.MAX_INSTR(2)) dut_m (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .instruction_type(instruction_type), .branch_taken(branch_taken),
        .mem_stall_I(mem_stall_I), .mem_stall_D(mem_stall_D),
        .mem_cen_I(m_mem_cen_I), .mem_cen_D(m_mem_cen_D), .mem_wen_D(m_mem_wen_D),
        .ir_we(m_ir_we), .pc_we(m_pc_we), .pc_sel(m_pc_sel), .reg_we(m_reg_we), .wb_sel(m_wb_sel),
        .retire(m_retire), .state(m_state), .instr_cnt(m_instr_cnt),
        .illegal(m_illegal), .timeout(m_timeout)
    );

    assign strobes = {mem_cen_I, mem_cen_D, mem_wen_D, ir_we, pc_we, pc_sel,
                      reg_we, wb_sel, retire, state};

    function automatic logic [13:0] pack(input logic cen_i, input logic cen_d, input logic wen_d,
                                         input logic ir, input logic pcwe, input logic [1:0] pcsel,
                                         input logic regwe, input logic [1:0] wbsel,
                                         input logic ret, input logic [2:0] st);
        return {cen_i, cen_d, wen_d, ir, pcwe, pcsel, regwe, wbsel, ret, st};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        start = 1'b0; stop = 1'b0; branch_taken = 1'b0;
        mem_stall_I = 1'b0; mem_stall_D = 1'b0; instruction_type = '0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        model_cnt = 0;
    endtask

    task automatic do_start(input string tag);
        quiet_inputs();
        start = 1'b1;
        #1;
        check({tag, ".idle"}, strobes, pack(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 3'd0));
        tick();
        start = 1'b0;
    endtask

    // Model: an instruction is a list of phases (FETCH x (1+stalls), DECODE, EXEC,
    // MEM x (1+stalls) for loads/stores, WB unless branch/store); it retires on its last phase.
    task automatic run_instr(input logic [22:0] it, input int fst, input int mst,
                             input logic taken, input logic stop_req, input string tag);
        int         ph[$];
        logic       br, lw, sw, jal, jalr, last;
        logic [1:0] e_pcsel, e_wbsel;
        br = it[20] | it[19]; lw = it[18]; sw = it[17]; jal = it[22]; jalr = it[21];
        for (int i = 0; i <= fst; i++) ph.push_back(1);
        ph.push_back(2);
        ph.push_back(3);
        if (lw || sw) for (int i = 0; i <= mst; i++) ph.push_back(4);
        if (!br && !sw) ph.push_back(5);
        for (int c = 0; c < ph.size(); c++) begin
            last             = (c == ph.size() - 1);
            instruction_type = it;
            branch_taken     = taken;
            mem_stall_I      = (c < fst);
            mem_stall_D      = (c >= fst + 3) && (c < fst + 3 + mst);
            stop             = last ? stop_req : 1'($urandom_range(0, 1));
            start            = 1'($urandom_range(0, 1));
            #1;
            e_pcsel = !last ? 2'd0 : br ? {1'b0, taken} : jal ? 2'd1 : jalr ? 2'd2 : 2'd0;
            e_wbsel = (ph[c] != 5) ? 2'd0 : lw ? 2'd1 : (jal || jalr) ? 2'd2 : 2'd0;
            check($sformatf("%s.c%0d", tag, c), strobes,
                  pack(ph[c] == 1, ph[c] == 4, ph[c] == 4 && sw, ph[c] == 1 && c == fst,
                       last, e_pcsel, ph[c] == 5, e_wbsel, last, 3'(ph[c])));
            tick();
        end
        model_cnt++;
        check({tag, ".cnt"}, instr_cnt, model_cnt);
        check({tag, ".next"}, state, stop_req ? 32'd0 : 32'd1);
        stop = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [22:0] it;
        int          sel;
        logic        stop_req;

        quiet_inputs();
        rst_n = 1'b1;
        tick();
        tick();
        check("rst.strobes", strobes, pack(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 3'd0));
        check("rst.cnt", instr_cnt, 0);
        check("rst.flags", {illegal, timeout}, 0);
        rst_n = 1'b0;

        do_start("s0");
        run_instr(23'h000100, 0, 0, 1'b0, 1'b0, "add");
        run_instr(23'h040000, 0, 3, 1'b0, 1'b0, "lw");
        run_instr(23'h080000, 0, 0, 1'b1, 1'b0, "bne_t");
        run_instr(23'h080000, 0, 0, 1'b0, 1'b0, "bne_n");

        do_reset();
        do_start("s1");
        run_instr(23'h200000, 0, 0, 1'b0, 1'b0, "jalr");
        run_instr(23'h020000, 1, 2, 1'b0, 1'b1, "sw_stop");

        // Non-one-hot decode aborts to IDLE without retiring.
        do_start("s2");
        #1;
        check("ill.fetch", state, 1);
        tick();
        instruction_type = 23'h000003;
        #1;
        check("ill.decode", state, 2);
        tick();
        quiet_inputs();
        check("ill.state", state, 0);
        check("ill.flag", illegal, 1);
        check("ill.cnt", instr_cnt, model_cnt);
        do_start("s3");
        check("ill.clear", illegal, 0);

        // Instruction memory stuck busy: 255 counted stall cycles, then timeout.
        mem_stall_I = 1'b1;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (c == 0 || c == 255) check($sformatf("to.fetch%0d", c), state, 1);
            if (c == 254 || c == 255) check($sformatf("to.cen%0d", c), mem_cen_I, (c == 254) ? 1 : 0);
            if (c == 256) begin
                check("to.idle", state, 0);
                check("to.flag", timeout, 1);
            end
            if (c == 299) check("to.hold", {state, timeout}, {3'd0, 1'b1});
            tick();
        end
        mem_stall_I = 1'b0;
        do_start("s4");
        check("to.clear", timeout, 0);

        // Retire limit on the MAX_INSTR=2 instance.
        do_reset();
        do_start("s5");
        run_instr(23'h000100, 0, 0, 1'b0, 1'b0, "max1");
        check("max1.m_state", m_state, 1);
        run_instr(23'h000100, 0, 0, 1'b0, 1'b0, "max2");
        check("max2.m_state", m_state, 0);
        check("max2.m_cnt", m_instr_cnt, 2);

        // Reset while a load is held in MEM.
        instruction_type = 23'h040000;
        mem_stall_D = 1'b1;
        tick();
        tick();
        tick();
        check("rmem.in_mem", {state, mem_cen_D}, {3'd4, 1'b1});
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        model_cnt = 0;
        check("rmem.strobes", strobes, pack(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 3'd0));
        check("rmem.cnt", instr_cnt, 0);
        quiet_inputs();

        // Random instruction stream.
        do_start("s6");
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: it = 23'h400000;
                1: it = 23'h200000;
                2: it = 23'h100000;
                3: it = 23'h080000;
                4: it = 23'h040000;
                5: it = 23'h020000;
                6: it = 23'd1 << $urandom_range(9, 16);
                default: it = 23'd1 << $urandom_range(0, 8);
            endcase
            stop_req = ($urandom_range(0, 7) == 0);
            run_instr(it, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      stop_req, $sformatf("rnd%0d", k));
            if (stop_req) do_start($sformatf("rs%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the RV32I-subset core. It consumes the 23-bit one-hot instruction_type from the instruction decoder and steps the shared datapath through FETCH/DECODE/EXEC/MEM/WB. It drives instruction and data memory enables, PC/IR/register-file write strobes and mux selects, and counts retired instructions.

Parameters:
MAX_INSTR, 0, retire limit; 0 = unlimited, else return to IDLE once instr_cnt reaches MAX_INSTR
STALL_LIMIT, 255, maximum consecutive stall cycles tolerated in FETCH or MEM (8-bit counter)

Ports:
clk  in  1  clock; one clock domain
rst_n  in  1  reset; synchronous and active-high (port name kept per codebase)
start  in  1  leave IDLE and begin fetching
stop  in  1  halt request; honoured at next retire
instruction_type  in  23  one-hot decode: b22 JAL, b21 JALR, b20 BEQ, b19 BNE, b18 LW, b17 SW, b16..b9 I-ALU, b8..b0 R-ALU
branch_taken  in  1  datapath compare result, valid in EXEC
mem_stall_I  in  1  instruction memory busy
mem_stall_D  in  1  data memory busy
mem_cen_I  out  1  instruction memory enable
mem_cen_D  out  1  data memory enable
mem_wen_D  out  1  data memory write enable
ir_we  out  1  latch instruction register
pc_we  out  1  update PC
pc_sel  out  2  0 PC+4, 1 PC+imm, 2 rs1+imm
reg_we  out  1  register-file write
wb_sel  out  2  0 ALU, 1 memory, 2 PC+4
retire  out  1  one-cycle pulse per completed instruction
state  out  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5
instr_cnt  out  32  retired-instruction count
illegal  out  1  sticky: decode was not one-hot
timeout  out  1  sticky: stall exceeded STALL_LIMIT

Behaviour:
- Reset (rst_n=1 at posedge): state=IDLE; instr_cnt, illegal, timeout, stall counter and latched type cleared. All strobes are 0 in IDLE. Reset mid-instruction aborts with no further strobes.
- Strobes are combinational from state, latched type and stall/branch inputs. They are asserted only in the states listed below and are 0 otherwise.
- IDLE: start=1 -> FETCH and clears illegal/timeout. start is ignored in other states.
- FETCH: mem_cen_I=1. If mem_stall_I=1, stay and increment stall counter. If mem_stall_I=0, ir_we=1, clear counter, go to DECODE.
- DECODE: one cycle; latch instruction_type. If popcount!=1, set illegal and go to IDLE with no retire. Otherwise go to EXEC.
- EXEC:
  - BEQ/BNE: pc_we=1, pc_sel = branch_taken ? 1 : 0; retire; go to FETCH.
  - LW/SW: go to MEM.
  - All others: go to WB.
- MEM: mem_cen_D=1; mem_wen_D=1 for SW. Hold while mem_stall_D=1, with the same stall counting. On mem_stall_D=0:
  - LW: go to WB.
  - SW: pc_we=1, pc_sel=0, retire, go to FETCH.
- WB: reg_we=1; pc_we=1; retire.
  - wb_sel: 1 for LW, 2 for JAL/JALR, else 0.
  - pc_sel: 1 for JAL, 2 for JALR, else 0.
  - Go to FETCH.
- Stall counter: resets on leaving FETCH/MEM. If it reaches STALL_LIMIT while the stall is still high, set timeout and go to IDLE. Strobes are deasserted that cycle.
- retire cycle:
  - instr_cnt increments by 1 and wraps at 2^32.
  - Next state is IDLE instead of FETCH if stop=1 or (MAX_INSTR!=0 and instr_cnt+1==MAX_INSTR).
  - stop outside a retire cycle is ignored.
- Latency with no stalls: branch 3 cycles (FETCH-DECODE-EXEC); ALU/JAL/JALR 4; SW 4; LW 5.

Test Plan:
- Reset, then start=1 with instruction_type=0x000100 (ADD) and no stalls -> states 1,2,3,5,1. reg_we=1, wb_sel=0, pc_we=1, pc_sel=0 in WB; instr_cnt=1.
- LW (0x040000) with mem_stall_D high 3 cycles -> MEM held 4 cycles with mem_cen_D=1 and mem_wen_D=0. WB has wb_sel=1; total 8 cycles from FETCH.
- BNE (0x080000): branch_taken=1 -> pc_sel=1 in EXEC; branch_taken=0 -> pc_sel=0. Neither case asserts reg_we; each retires in 3 cycles.
- JALR (0x200000) then SW (0x020000) with stop=1 during SW's MEM retire:
  - JALR WB: pc_sel=2, wb_sel=2.
  - SW: mem_wen_D=1.
  - Returns to IDLE with instr_cnt=2.
- instruction_type=0x000003 in DECODE -> illegal=1, state IDLE, instr_cnt unchanged. mem_stall_I held 300 cycles with STALL_LIMIT=255 -> timeout=1, IDLE.
- MAX_INSTR=2, continuous ADDs -> IDLE after 2nd retire. rst_n=1 asserted in MEM -> next cycle IDLE, all strobes 0, instr_cnt=0.
